matmul_sequencer: RTL and testbench

//  Upstream controller for the MatMul energy engine. Accepts one command: sigma, previous energy and J base address.

---
 rtl/matmul_sequencer_pkg.sv | 31 +++
 rtl/matmul_sequencer_if.sv | 40 ++++
 rtl/matmul_sequencer.sv | 113 +++++++++++
 tb/tb_matmul_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_sequencer_pkg.sv
// rtl/matmul_sequencer_pkg.sv - derived sizes, FSM states and J chunk layout for the MatMul sequencer
package matmul_sequencer_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_RUN    = 2'd1,
      SEQ_DRAIN  = 2'd2,
      SEQ_RESULT = 2'd3
   } seq_state_e;

   function automatic int j_cols_per_read(input int mem_bandwidth, input int vector_size,
                                          input int j_element_width);
      return mem_bandwidth / (vector_size * j_element_width);
   endfunction

   function automatic int num_j_chunks(input int mem_bandwidth, input int vector_size,
                                       input int j_element_width);
      return vector_size / j_cols_per_read(mem_bandwidth, vector_size, j_element_width);
   endfunction

   function automatic int energy_width(input int vector_size, input int j_element_width);
      return 2 * $clog2(vector_size) + j_element_width + 1;
   endfunction

   // Bit offset of J element [r][c] (c local to the word) inside one SRAM word.
   function automatic int chunk_bit_offset(input int r, input int c, input int cols_per_read,
                                           input int j_element_width);
      return (r * cols_per_read + c) * j_element_width;
   endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// rtl/matmul_sequencer_if.sv - command, SRAM, MatMul and result signals of the MatMul sequencer
interface matmul_sequencer_if #(
   parameter int VECTOR_SIZE   = 256,
   parameter int MEM_BANDWIDTH = 1024,
   parameter int ADDR_WIDTH    = 16,
   parameter int ENERGY_WIDTH  = matmul_sequencer_pkg::energy_width(256, 4)
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [VECTOR_SIZE-1:0]   cmd_sigma;
   logic [ENERGY_WIDTH-1:0]  cmd_energy_prev;
   logic [ADDR_WIDTH-1:0]    cmd_base_addr;
   logic                     abort;
   logic                     mem_req;
   logic [ADDR_WIDTH-1:0]    mem_addr;
   logic [MEM_BANDWIDTH-1:0] mem_rdata;
   logic                     mm_start;
   logic [VECTOR_SIZE-1:0]   mm_sigma;
   logic [ENERGY_WIDTH-1:0]  mm_energy_prev;
   logic [MEM_BANDWIDTH-1:0] mm_j_chunk;
   logic [ENERGY_WIDTH-1:0]  mm_energy;
   logic                     res_valid;
   logic                     res_ready;
   logic [ENERGY_WIDTH-1:0]  res_energy;
   logic                     res_accept;

   modport slave (
      input  cmd_valid, cmd_sigma, cmd_energy_prev, cmd_base_addr, abort,
      input  mem_rdata, mm_energy, res_ready,
      output cmd_ready, mem_req, mem_addr, mm_start, mm_sigma, mm_energy_prev,
      output mm_j_chunk, res_valid, res_energy, res_accept
   );

   modport master (
      output cmd_valid, cmd_sigma, cmd_energy_prev, cmd_base_addr, abort,
      output mem_rdata, mm_energy, res_ready,
      input  cmd_ready, mem_req, mem_addr, mm_start, mm_sigma, mm_energy_prev,
      input  mm_j_chunk, res_valid, res_energy, res_accept
   );
endinterface

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - streams J chunks from SRAM into MatMul for one command and returns the energy
module matmul_sequencer
   import matmul_sequencer_pkg::*;
#(
   parameter int MEM_BANDWIDTH   = 1024,
   parameter int VECTOR_SIZE     = 256,
   parameter int J_ELEMENT_WIDTH = 4,
   parameter int ADDR_WIDTH      = 16,
   parameter int MEM_LATENCY     = 2
) (
   input logic clk,
   input logic rst_n,
   matmul_sequencer_if.slave bus
);
   localparam int NUM_CHUNKS = num_j_chunks(MEM_BANDWIDTH, VECTOR_SIZE, J_ELEMENT_WIDTH);
   localparam int CAP_T      = MEM_LATENCY + NUM_CHUNKS;
   localparam int CW         = $clog2(CAP_T + 1);

   localparam logic [CW-1:0] T_CAP    = CW'(CAP_T);
   localparam logic [CW-1:0] T_START  = CW'(MEM_LATENCY - 1);
   localparam logic [CW-1:0] T_CHUNKS = CW'(NUM_CHUNKS);

   seq_state_e            state;
   logic [CW-1:0]         t;
   logic [CW-1:0]         t_nxt;
   logic [ADDR_WIDTH-1:0] base;

   assign t_nxt          = t + CW'(1);
   assign bus.mm_j_chunk = bus.mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= SEQ_IDLE;
         t                  <= '0;
         base               <= '0;
         bus.cmd_ready      <= 1'b1;
         bus.mem_req        <= 1'b0;
         bus.mem_addr       <= '0;
         bus.mm_start       <= 1'b0;
         bus.mm_sigma       <= '0;
         bus.mm_energy_prev <= '0;
         bus.res_valid      <= 1'b0;
         bus.res_energy     <= '0;
         bus.res_accept     <= 1'b0;
      end else begin
         bus.mm_start <= 1'b0;
         case (state)
            SEQ_IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  bus.mm_sigma       <= bus.cmd_sigma;
                  bus.mm_energy_prev <= bus.cmd_energy_prev;
                  base               <= bus.cmd_base_addr;
                  t                  <= '0;
                  bus.mem_req        <= 1'b1;
                  bus.mem_addr       <= bus.cmd_base_addr;
                  bus.mm_start       <= (MEM_LATENCY == 1);
                  bus.cmd_ready      <= 1'b0;
                  state              <= SEQ_RUN;
               end
            end
            SEQ_RUN: begin
               t <= t_nxt;
               // MatMul clears its energy on the next edge, so capture cannot wait a cycle.
               if (t == T_CAP) begin
                  bus.mem_req <= 1'b0;
                  if (bus.abort) begin
                     bus.cmd_ready <= 1'b1;
                     state         <= SEQ_IDLE;
                  end else begin
                     bus.res_energy <= bus.mm_energy;
                     bus.res_accept <= $signed(bus.mm_energy) < $signed(bus.mm_energy_prev);
                     bus.res_valid  <= 1'b1;
                     state          <= SEQ_RESULT;
                  end
               end else if (bus.abort) begin
                  bus.mem_req <= 1'b0;
                  if (t < T_START) begin
                     bus.cmd_ready <= 1'b1;
                     state         <= SEQ_IDLE;
                  end else begin
                     state <= SEQ_DRAIN;
                  end
               end else begin
                  bus.mem_req  <= (t_nxt < T_CHUNKS);
                  bus.mm_start <= (t_nxt == T_START);
                  if (t_nxt < T_CHUNKS) begin
                     bus.mem_addr <= base + ADDR_WIDTH'(t_nxt);
                  end
               end
            end
            SEQ_DRAIN: begin
               // MatMul is already running; wait out its capture cycle and drop the result.
               t <= t_nxt;
               if (t == T_CAP) begin
                  bus.cmd_ready <= 1'b1;
                  state         <= SEQ_IDLE;
               end
            end
            SEQ_RESULT: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= SEQ_IDLE;
               end
            end
            default: begin
               bus.cmd_ready <= 1'b1;
               state         <= SEQ_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - directed and randomized runs of matmul_sequencer against a reference energy model
module tb_matmul_sequencer;
   localparam int VS   = 8;
   localparam int JW   = 4;
   localparam int MB   = 32;
   localparam int AW   = 16;
   localparam int L    = 2;
   localparam int COLS = MB / (VS * JW);
   localparam int N    = VS / COLS;
   localparam int EW   = 2 * $clog2(VS) + JW + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int checks   = 0;
   int failures = 0;

   matmul_sequencer_if #(.VECTOR_SIZE(VS), .MEM_BANDWIDTH(MB), .ADDR_WIDTH(AW), .ENERGY_WIDTH(EW)) bus ();

   matmul_sequencer #(
      .MEM_BANDWIDTH(MB), .VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(JW), .ADDR_WIDTH(AW), .MEM_LATENCY(L)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // SRAM with fixed read latency; a non-requested slot returns a poison word
   logic [MB-1:0] mem [0:65535];
   logic [MB-1:0] rd_pipe [L];
   always @(posedge clk) begin
      rd_pipe[0] <= bus.mem_req ? mem[bus.mem_addr] : 32'hDEAD_BEEF;
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata = rd_pipe[L-1];

   function automatic int col_term(input logic [MB-1:0] chunk, input logic [VS-1:0] sg, input int c);
      int s;
      s = 0;
      for (int r = 0; r < VS; r++) s += int'($signed(chunk[r*JW +: JW])) * (sg[r] ? 1 : -1);
      return sg[c] ? s : -s;
   endfunction

   // MatMul stand-in: counter k starts the cycle after mm_start, energy valid for one cycle only
   logic          mm_act;
   int            mm_k;
   int            mm_acc;
   logic [MB-1:0] chunks_seen [N];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mm_act        <= 1'b0;
         mm_k          <= 0;
         mm_acc        <= 0;
         bus.mm_energy <= '0;
      end else begin
         bus.mm_energy <= '0;
         if (bus.mm_start) begin
            mm_act <= 1'b1;
            mm_k   <= 0;
            mm_acc <= 0;
         end else if (mm_act) begin
            chunks_seen[mm_k[2:0]] <= bus.mm_j_chunk;
            if (mm_k == N - 1) begin
               bus.mm_energy <= EW'(mm_acc + col_term(bus.mm_j_chunk, bus.mm_sigma, mm_k));
               mm_act        <= 1'b0;
            end else begin
               mm_acc <= mm_acc + col_term(bus.mm_j_chunk, bus.mm_sigma, mm_k);
               mm_k   <= mm_k + 1;
            end
         end
      end
   end

   function automatic logic [EW-1:0] ref_energy(input logic [VS-1:0] sg, input logic [AW-1:0] base);
      int e;
      logic [MB-1:0] w;
      e = 0;
      for (int r = 0; r < VS; r++) begin
         for (int c = 0; c < VS; c++) begin
            w = mem[AW'(base + AW'(c / COLS))];
            e += int'($signed(w[(r*COLS + c%COLS)*JW +: JW])) * (sg[r] ? 1 : -1) * (sg[c] ? 1 : -1);
         end
      end
      return EW'(e);
   endfunction

   task automatic fill(input logic [AW-1:0] base, input int mode);
      for (int k = 0; k < N; k++) mem[AW'(base + AW'(k))] = (mode == 0) ? 32'h1111_1111 : $urandom;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the sequencer back in IDLE.
   task automatic run_cmd(input string tag, input logic [VS-1:0] sg, input logic [EW-1:0] prev,
                          input logic [AW-1:0] base, input int abort_t, input int stall,
                          input bit keep_valid);
      logic [EW-1:0] exp_e, held;
      logic          exp_acc;
      logic [15:0]   req_obs, start_obs, req_exp, start_exp;
      int            w, cyc, first_rv, first_rdy, addr_err, hold_err, bad;
      exp_e   = ref_energy(sg, base);
      exp_acc = $signed(exp_e) < $signed(prev);
      bus.cmd_valid       = 1'b1;
      bus.cmd_sigma       = sg;
      bus.cmd_energy_prev = prev;
      bus.cmd_base_addr   = base;
      bus.res_ready       = (stall == 0);
      w = 0;
      while (!bus.cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      if (!keep_valid) bus.cmd_valid = 1'b0;
      req_obs = '0; start_obs = '0; addr_err = 0; hold_err = 0;
      first_rv = -1; first_rdy = -1; cyc = 0;
      while (cyc < 16) begin
         bus.abort = (cyc == abort_t);
         req_obs[cyc]   = bus.mem_req;
         start_obs[cyc] = bus.mm_start;
         if (bus.mem_req && bus.mem_addr !== AW'(base + AW'(cyc))) addr_err++;
         if (bus.mm_sigma !== sg || bus.mm_energy_prev !== prev) hold_err++;
         if (bus.cmd_ready && first_rdy < 0) first_rdy = cyc;
         if (bus.res_valid) begin
            first_rv = cyc;
            break;
         end
         if (abort_t >= 0 && cyc == 13) break;
         @(negedge clk);
         cyc++;
      end
      bus.abort = 1'b0;
      for (int i = 0; i < 16; i++) begin
         req_exp[i]   = (i < N) && (abort_t < 0 || i <= abort_t);
         start_exp[i] = (i == L - 1) && (abort_t < 0 || abort_t >= L - 1);
      end
      chk({tag, ".mem_req"}, 64'(req_obs), 64'(req_exp));
      chk({tag, ".mm_start"}, 64'(start_obs), 64'(start_exp));
      chk({tag, ".mem_addr"}, 64'(addr_err), 64'd0);
      chk({tag, ".sigma_hold"}, 64'(hold_err), 64'd0);
      if (abort_t < 0) begin
         chk({tag, ".latency"}, 64'(first_rv), 64'(L + N + 1));
         chk({tag, ".busy"}, 64'(first_rdy), 64'(-1));
         bad = 0;
         for (int k = 0; k < N; k++) if (chunks_seen[k] !== mem[AW'(base + AW'(k))]) bad++;
         chk({tag, ".chunks"}, 64'(bad), 64'd0);
         chk({tag, ".energy"}, 64'(bus.res_energy), 64'(exp_e));
         chk({tag, ".accept"}, 64'(bus.res_accept), 64'(exp_acc));
         held = bus.res_energy;
         bad  = 0;
         for (int i = 0; i < stall; i++) begin
            if (!(bus.res_valid === 1'b1 && bus.res_energy === held && bus.cmd_ready === 1'b0)) bad++;
            @(negedge clk);
         end
         if (stall > 0) chk({tag, ".stall_hold"}, 64'(bad), 64'd0);
         bus.res_ready = 1'b1;
         @(negedge clk);
         chk({tag, ".res_released"}, 64'(bus.res_valid), 64'd0);
         chk({tag, ".ready_after"}, 64'(bus.cmd_ready), 64'd1);
      end else begin
         chk({tag, ".no_result"}, 64'(first_rv), 64'(-1));
         chk({tag, ".ready_return"}, 64'(first_rdy), 64'((abort_t < L - 1) ? 1 : L + N + 1));
      end
   endtask

   initial begin
      logic [VS-1:0] sg;
      logic [EW-1:0] prev;
      logic [AW-1:0] base;
      bus.cmd_valid       = 1'b0;
      bus.cmd_sigma       = '0;
      bus.cmd_energy_prev = '0;
      bus.cmd_base_addr   = '0;
      bus.abort           = 1'b0;
      bus.res_ready       = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.cmd_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst.mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst.mm_start", 64'(bus.mm_start), 64'd0);
      chk("rst.res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst.res_accept", 64'(bus.res_accept), 64'd0);
      chk("rst.mm_sigma", 64'(bus.mm_sigma), 64'd0);
      chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      fill(16'h0010, 0);
      run_cmd("nominal", 8'hFF, 11'd0, 16'h0010, -1, 0, 1'b0);
      chk("nominal.e64", 64'(bus.res_energy), 64'd64);
      chk("nominal.acc0", 64'(bus.res_accept), 64'd0);

      fill(16'h0200, 0);
      run_cmd("prev_m10", 8'h00, 11'h7F6, 16'h0200, -1, 0, 1'b0);
      chk("prev_m10.e64", 64'(bus.res_energy), 64'd64);
      chk("prev_m10.acc0", 64'(bus.res_accept), 64'd0);
      run_cmd("prev_100", 8'h00, 11'd100, 16'h0200, -1, 0, 1'b0);
      chk("prev_100.acc1", 64'(bus.res_accept), 64'd1);

      for (int i = 0; i < 5; i++) begin
         base = (i == 0) ? 16'hFFFC : AW'($urandom);
         sg   = VS'($urandom);
         fill(base, 1);
         prev = (i == 1) ? ref_energy(sg, base) : EW'(int'($urandom_range(0, 1023)) - 512);
         run_cmd("rand", sg, prev, base, -1, 0, 1'b0);
      end

      fill(16'h0400, 1);
      fill(16'h0500, 1);
      run_cmd("bp", VS'($urandom), EW'($urandom), 16'h0400, -1, 5, 1'b1);
      run_cmd("bp_next", VS'($urandom), EW'($urandom), 16'h0500, -1, 0, 1'b0);

      fill(16'h0600, 1);
      run_cmd("abort_t0", 8'hA5, 11'd0, 16'h0600, 0, 0, 1'b0);
      run_cmd("abort_t4", 8'h3C, 11'd5, 16'h0600, 4, 0, 1'b0);
      run_cmd("post_abort", 8'h3C, 11'd5, 16'h0600, -1, 0, 1'b0);

      fill(16'h0700, 1);
      bus.cmd_sigma       = 8'h5A;
      bus.cmd_energy_prev = 11'd33;
      bus.cmd_base_addr   = 16'h0700;
      bus.cmd_valid       = 1'b1;
      chk("rst_mid.cmd_ready", 64'(bus.cmd_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid.mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mid.mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_mid.mm_start", 64'(bus.mm_start), 64'd0);
      chk("rst_mid.mm_sigma", 64'(bus.mm_sigma), 64'd0);
      chk("rst_mid.mm_energy_prev", 64'(bus.mm_energy_prev), 64'd0);
      chk("rst_mid.res_energy", 64'(bus.res_energy), 64'd0);
      chk("rst_mid.res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_mid.res_accept", 64'(bus.res_accept), 64'd0);
      chk("rst_mid.cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_cmd("after_rst", 8'h5A, 11'd33, 16'h0700, -1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
